sd_cmd_scheduler: RTL

Sequences the single SD command engine between two requesters: software-issued commands (Command register write) and hardware Auto CMD12 requests raised by the data-line controller at the end of a multi-block transfer. It runs in the register clock domain, between the register file and the command engine. It owns the Command Inhibit (CMD) and Command Inhibit (DAT) status bits, enforces the command-issue rules, and supervises each command with a response timeout.

---
 rtl/sdhci_pkg.sv | 23 ++
 rtl/cmd_timeout_counter.sv | 39 +++
 rtl/sd_cmd_scheduler.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sdhci_pkg.sv
// Shared SDHCI command-path types: scheduler state encoding, response types
// and the fixed Auto CMD12 payload.
package sdhci_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE_SW   = 3'd1,
        ST_WAIT_SW    = 3'd2,
        ST_ISSUE_AUTO = 3'd3,
        ST_WAIT_AUTO  = 3'd4
    } cmd_sched_state_e;

    typedef enum logic [1:0] {
        RSP_NONE = 2'b00,
        RSP_R136 = 2'b01,
        RSP_R48  = 2'b10,
        RSP_R48B = 2'b11
    } rsp_type_e;

    localparam logic [5:0]  CMD12_INDEX = 6'd12;
    localparam logic [31:0] CMD12_ARG   = 32'h0;

endpackage

// File: rtl/cmd_timeout_counter.sv
// Response timeout supervisor: counts WAIT cycles after a command handshake
// and flags expiry on the cycle the count reaches TimeoutCycles.
module cmd_timeout_counter #(
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned TimeoutWidth  = $clog2(TimeoutCycles + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam logic [TimeoutWidth-1:0] Limit = TimeoutWidth'(TimeoutCycles);

    logic [TimeoutWidth-1:0] cnt_q;
    logic [TimeoutWidth-1:0] cnt_d;

    // Saturates at Limit so a late caller never sees the count wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i && (cnt_q != Limit)) begin
            cnt_d = cnt_q + TimeoutWidth'(1);
        end
    end

    assign expired_o = run_i && !clear_i && (cnt_d == Limit);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sd_cmd_scheduler.sv
// Arbitrates the SD command engine between software commands and Auto CMD12.
// The Auto CMD12 path is built only when SDHCI_AUTO_CMD12_EN is defined.
//
// state      | meaning
// IDLE       | no command outstanding; accepts software or Auto CMD12
// ISSUE_SW   | software command offered to the engine, waiting for ready
// WAIT_SW    | software command accepted, waiting for done or timeout
// ISSUE_AUTO | Auto CMD12 offered to the engine, waiting for ready
// WAIT_AUTO  | Auto CMD12 accepted, waiting for done or timeout
import sdhci_pkg::*;

module sd_cmd_scheduler #(
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned TimeoutWidth  = $clog2(TimeoutCycles + 1)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sw_cmd_valid_i,
    input  logic [5:0]  sw_cmd_index_i,
    input  logic [31:0] sw_cmd_arg_i,
    input  logic [1:0]  sw_rsp_type_i,
    input  logic        sw_data_present_i,
    input  logic        auto_cmd12_req_i,
    input  logic        dat_xfer_done_i,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic [5:0]  cmd_index_o,
    output logic [31:0] cmd_arg_o,
    output logic [1:0]  cmd_rsp_type_o,
    input  logic        cmd_done_i,
    input  logic        cmd_crc_err_i,
    output logic        cmd_inhibit_o,
    output logic        dat_inhibit_o,
    output logic        sw_cmd_complete_o,
    output logic        sw_cmd_dropped_o,
    output logic        sw_timeout_err_o,
    output logic        auto_cmd12_done_o,
    output logic        auto_cmd12_timeout_o,
    output logic        auto_cmd12_crc_err_o
);

    cmd_sched_state_e state_q;
    logic             cmd_valid_q;
    logic [5:0]       cmd_index_q;
    logic [31:0]      cmd_arg_q;
    rsp_type_e        cmd_rsp_q;
    logic             cmd_inh_q;
    logic             dat_inh_q;
    logic             data_q;
    logic             sw_complete_q;
    logic             sw_dropped_q;
    logic             sw_timeout_q;

    logic auto_go;
    logic sw_violation;
    logic sw_accept;
    logic in_wait;
    logic handshake;
    logic expired;

`ifdef SDHCI_AUTO_CMD12_EN
    logic auto_pending_q;
    logic auto_done_q;
    logic auto_timeout_q;
    logic auto_crc_q;

    // A request arriving in the same IDLE cycle is served at once.
    assign auto_go = auto_pending_q | auto_cmd12_req_i;
`else
    logic unused_auto;

    assign unused_auto = auto_cmd12_req_i ^ cmd_crc_err_i;
    assign auto_go     = 1'b0;
`endif

    assign sw_violation = cmd_inh_q | (sw_data_present_i & dat_inh_q);
    assign sw_accept    = (state_q == ST_IDLE) && sw_cmd_valid_i && !auto_go && !sw_violation;
    assign in_wait      = (state_q == ST_WAIT_SW) || (state_q == ST_WAIT_AUTO);
    assign handshake    = cmd_valid_q && cmd_ready_i;

    cmd_timeout_counter #(
        .TimeoutCycles(TimeoutCycles),
        .TimeoutWidth (TimeoutWidth)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (handshake),
        .run_i    (in_wait),
        .expired_o(expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            cmd_valid_q    <= 1'b0;
            cmd_index_q    <= '0;
            cmd_arg_q      <= '0;
            cmd_rsp_q      <= RSP_NONE;
            cmd_inh_q      <= 1'b0;
            dat_inh_q      <= 1'b0;
            data_q         <= 1'b0;
            sw_complete_q  <= 1'b0;
            sw_dropped_q   <= 1'b0;
            sw_timeout_q   <= 1'b0;
`ifdef SDHCI_AUTO_CMD12_EN
            auto_pending_q <= 1'b0;
            auto_done_q    <= 1'b0;
            auto_timeout_q <= 1'b0;
            auto_crc_q     <= 1'b0;
`endif
        end else begin
            sw_complete_q <= 1'b0;
            sw_timeout_q  <= 1'b0;
            sw_dropped_q  <= sw_cmd_valid_i && !sw_accept;
`ifdef SDHCI_AUTO_CMD12_EN
            auto_done_q    <= 1'b0;
            auto_timeout_q <= 1'b0;
            auto_crc_q     <= 1'b0;
            auto_pending_q <= auto_pending_q | auto_cmd12_req_i;
`endif
            // CMD inhibit drops one cycle after the completion/timeout pulse.
            if (sw_complete_q || sw_timeout_q) begin
                cmd_inh_q <= 1'b0;
            end
            if (dat_xfer_done_i) begin
                dat_inh_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
`ifdef SDHCI_AUTO_CMD12_EN
                    if (auto_go) begin
                        state_q        <= ST_ISSUE_AUTO;
                        auto_pending_q <= 1'b0;
                        cmd_valid_q    <= 1'b1;
                        cmd_index_q    <= CMD12_INDEX;
                        cmd_arg_q      <= CMD12_ARG;
                        cmd_rsp_q      <= RSP_R48B;
                    end else
`endif
                    if (sw_accept) begin
                        state_q     <= ST_ISSUE_SW;
                        cmd_valid_q <= 1'b1;
                        cmd_index_q <= sw_cmd_index_i;
                        cmd_arg_q   <= sw_cmd_arg_i;
                        cmd_rsp_q   <= rsp_type_e'(sw_rsp_type_i);
                        cmd_inh_q   <= 1'b1;
                        data_q      <= sw_data_present_i;
                        if (sw_data_present_i) begin
                            dat_inh_q <= 1'b1;
                        end
                    end
                end
                ST_ISSUE_SW: begin
                    if (cmd_ready_i) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= ST_WAIT_SW;
                    end
                end
                ST_WAIT_SW: begin
                    if (cmd_done_i) begin
                        sw_complete_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else if (expired) begin
                        sw_timeout_q <= 1'b1;
                        if (data_q) begin
                            dat_inh_q <= 1'b0;
                        end
                        state_q <= ST_IDLE;
                    end
                end
`ifdef SDHCI_AUTO_CMD12_EN
                ST_ISSUE_AUTO: begin
                    if (cmd_ready_i) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= ST_WAIT_AUTO;
                    end
                end
                ST_WAIT_AUTO: begin
                    if (cmd_done_i) begin
                        auto_done_q <= 1'b1;
                        auto_crc_q  <= cmd_crc_err_i;
                        state_q     <= ST_IDLE;
                    end else if (expired) begin
                        auto_timeout_q <= 1'b1;
                        state_q        <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_valid_o       = cmd_valid_q;
    assign cmd_index_o       = cmd_index_q;
    assign cmd_arg_o         = cmd_arg_q;
    assign cmd_rsp_type_o    = cmd_rsp_q;
    assign cmd_inhibit_o     = cmd_inh_q;
    assign dat_inhibit_o     = dat_inh_q;
    assign sw_cmd_complete_o = sw_complete_q;
    assign sw_cmd_dropped_o  = sw_dropped_q;
    assign sw_timeout_err_o  = sw_timeout_q;

`ifdef SDHCI_AUTO_CMD12_EN
    assign auto_cmd12_done_o    = auto_done_q;
    assign auto_cmd12_timeout_o = auto_timeout_q;
    assign auto_cmd12_crc_err_o = auto_crc_q;
`else
    assign auto_cmd12_done_o    = 1'b0;
    assign auto_cmd12_timeout_o = 1'b0;
    assign auto_cmd12_crc_err_o = 1'b0;
`endif

endmodule
